ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the ALU. Registers ALU result/flags and EX control,
//  resolves conditional branches from Z/N, flags misaligned accesses, drives MEM-stage forwarding.
//  Supports stall (hold) and flush (bubble); keeps a wrapping count of taken branches.
// PARAMETERS
//  CNT_W  16  width of taken-branch counter
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  stall           in   1      hold all stage registers
//  flush           in   1      load bubble (overrides stall)
//  ex_valid        in   1      EX stage holds a real instruction
//  ex_alu_out      in   32     ALU Out
//  ex_z / ex_n     in   1 each ALU Z / N flags
//  ex_store_data   in   32     rt value for stores
//  ex_rd           in   5      destination register
//  ex_reg_write    in   1      writeback enable
//  ex_mem_read     in   1      load
//  ex_mem_write    in   1      store
//  ex_mem_size     in   2      00 byte, 01 half, 10 word, 11 rsvd(=word)
//  ex_br_cond      in   3      branch condition code (see BEHAVIOUR)
//  ex_br_target    in   32     branch target address
//  mem_valid       out  1      MEM holds real instruction
//  mem_alu_out     out  32     registered result / address
//  mem_store_data  out  32     registered store data
//  mem_rd          out  5      registered destination
//  mem_reg_write   out  1      qualified writeback enable
//  mem_mem_read    out  1      qualified load
//  mem_mem_write   out  1      qualified store
//  mem_mem_size    out  2      registered size
//  mem_misalign    out  1      access suppressed: misaligned
//  mem_br_taken    out  1      branch resolved taken (one cycle per instruction)
//  mem_br_target   out  32     registered target
//  fwd_valid       out  1      fwd_data usable by ALU operand mux
//  fwd_rd          out  5      = mem_rd
//  fwd_data        out  32     = mem_alu_out
//  br_taken_cnt    out  CNT_W  taken branches captured, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset: all outputs and registers 0; asynchronous assert, synchronous release.
//  - Priority per edge: flush > stall > capture. Latency 1 cycle EX->MEM.
//  - flush: mem_valid and all control outs (reg_write, mem_read, mem_write, misalign, br_taken) <- 0;
//    data regs may hold. Counter unchanged. flush with stall together = flush.
//  - stall: every register, counter included, holds; mem_br_taken stays at held value (no re-count).
//  - capture with ex_valid=0: same as flush.
//  - capture with ex_valid=1: register all inputs; misalign = mem_read|mem_write AND
//    (word: alu_out[1:0]!=0; half: alu_out[0]!=0; byte: never). If misalign: mem_read, mem_write,
//    reg_write outputs 0, mem_misalign 1, mem_valid stays 1.
//  - br_cond: 000 none, 001 EQ(Z), 010 NE(!Z), 011 LEZ(Z|N), 100 GTZ(!Z&!N), 101 LTZ(N),
//    110 GEZ(!N), 111 always. mem_br_taken = eval(ex_br_cond, ex_z, ex_n) at capture.
//  - br_taken_cnt increments by 1 on each capture edge with taken=1; all-ones wraps to 0.
//  - fwd_valid = mem_valid & mem_reg_write & !mem_mem_read & (mem_rd!=0). Loads never forward here.
//  - rd=0 with reg_write: captured as-is; only fwd_valid is suppressed.
// STRUCTURE
//  - Shared package mips_pkg: BR_* condition codes (3b), MSZ_BYTE/HALF/WORD (2b).
//  - Sub-module branch_cond_eval (combinational: cond, z, n -> taken); rest is flat register logic.
// TESTING
//  1 Reset: rst_n=0 mid-stream with mem_valid=1 -> all outputs 0 immediately, cnt=0.
//  2 Capture: ex_valid=1, alu_out=0x0000_1004, rd=5, reg_write=1 -> next cycle mem_alu_out=0x1004,
//    fwd_valid=1, fwd_rd=5; same with rd=0 -> fwd_valid=0.
//  3 Branch: cond=001,Z=1 -> mem_br_taken=1, cnt 0->1; cond=101,N=0 -> taken=0; cond=011,N=1 -> 1.
//  4 Stall/flush: taken branch then stall=1 x3 -> outputs held, cnt stays 1; flush=1,stall=1 ->
//    mem_valid=0, br_taken=0.
//  5 Misalign: mem_read=1, size=10, alu_out=0x1002 -> mem_misalign=1, mem_mem_read=0,
//    mem_reg_write=0; size=00 same address -> misalign=0.
//  6 Wrap: CNT_W=4, 16 taken branches -> br_taken_cnt returns to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style pipeline: branch condition codes, access sizes,
// and the alignment rule used by the memory-facing stages.
package mips_pkg;

    localparam logic [2:0] BR_NONE   = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_LEZ    = 3'b011;
    localparam logic [2:0] BR_GTZ    = 3'b100;
    localparam logic [2:0] BR_LTZ    = 3'b101;
    localparam logic [2:0] BR_GEZ    = 3'b110;
    localparam logic [2:0] BR_ALWAYS = 3'b111;

    localparam logic [1:0] MSZ_BYTE = 2'b00;
    localparam logic [1:0] MSZ_HALF = 2'b01;
    localparam logic [1:0] MSZ_WORD = 2'b10;
    localparam logic [1:0] MSZ_RSVD = 2'b11;

    // Reserved size behaves as a word access.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        unique case (size)
            MSZ_BYTE: mis = 1'b0;
            MSZ_HALF: mis = addr_lo[0];
            MSZ_WORD,
            MSZ_RSVD: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution from the ALU zero/negative flags of (rs - rt) or rs.
module branch_cond_eval
    import mips_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            BR_NONE:   taken = 1'b0;
            BR_EQ:     taken = z;
            BR_NE:     taken = ~z;
            BR_LEZ:    taken = z | n;
            BR_GTZ:    taken = ~z & ~n;
            BR_LTZ:    taken = n;
            BR_GEZ:    taken = ~n;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: captures ALU results and control, resolves branches,
// suppresses misaligned accesses, drives MEM-stage forwarding and counts taken branches.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [31:0]      ex_alu_out,
    input  logic             ex_z,
    input  logic             ex_n,
    input  logic [31:0]      ex_store_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [1:0]       ex_mem_size,
    input  logic [2:0]       ex_br_cond,
    input  logic [31:0]      ex_br_target,
    output logic             mem_valid,
    output logic [31:0]      mem_alu_out,
    output logic [31:0]      mem_store_data,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [1:0]       mem_mem_size,
    output logic             mem_misalign,
    output logic             mem_br_taken,
    output logic [31:0]      mem_br_target,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] br_taken_cnt
);

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    logic             ex_taken;
    logic             ex_misalign;
    logic             ex_is_mem;

    branch_cond_eval u_branch_cond_eval (
        .cond  (ex_br_cond),
        .z     (ex_z),
        .n     (ex_n),
        .taken (ex_taken)
    );

    assign ex_is_mem   = ex_mem_read | ex_mem_write;
    assign ex_misalign = ex_is_mem & addr_misaligned(ex_mem_size, ex_alu_out[1:0]);

    logic             valid_q,     valid_d;
    logic [31:0]      alu_q,       alu_d;
    logic [31:0]      sdata_q,     sdata_d;
    logic [4:0]       rd_q,        rd_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [1:0]       size_q,      size_d;
    logic             misalign_q,  misalign_d;
    logic             br_taken_q,  br_taken_d;
    logic [31:0]      target_q,    target_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        sdata_d     = sdata_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        size_d      = size_q;
        misalign_d  = misalign_q;
        br_taken_d  = br_taken_q;
        target_d    = target_q;
        cnt_d       = cnt_q;

        // A bubble clears control only; data registers keep their last contents.
        if (flush || (!stall && !ex_valid)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            misalign_d  = 1'b0;
            br_taken_d  = 1'b0;
        end else if (!stall) begin
            valid_d     = 1'b1;
            alu_d       = ex_alu_out;
            sdata_d     = ex_store_data;
            rd_d        = ex_rd;
            reg_write_d = ex_reg_write & ~ex_misalign;
            mem_read_d  = ex_mem_read & ~ex_misalign;
            mem_write_d = ex_mem_write & ~ex_misalign;
            size_d      = ex_mem_size;
            misalign_d  = ex_misalign;
            br_taken_d  = ex_taken;
            target_d    = ex_br_target;
            cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, ex_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            sdata_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            size_q      <= '0;
            misalign_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            target_q    <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            sdata_q     <= sdata_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            size_q      <= size_d;
            misalign_q  <= misalign_d;
            br_taken_q  <= br_taken_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_out    = alu_q;
    assign mem_store_data = sdata_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_mem_size   = size_q;
    assign mem_misalign   = misalign_q;
    assign mem_br_taken   = br_taken_q;
    assign mem_br_target  = target_q;
    assign br_taken_cnt   = cnt_q;

    // Load data is not available until after MEM, so loads never forward from here.
    assign fwd_valid = valid_q & reg_write_q & ~mem_read_q & (rd_q != 5'd0);
    assign fwd_rd    = rd_q;
    assign fwd_data  = alu_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes reference-model predictions,
// a monitor pops and compares one prediction per clock edge.
module tb_ex_mem_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, ex_valid, ex_z, ex_n;
    logic [31:0]   ex_alu_out, ex_store_data, ex_br_target;
    logic [4:0]    ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]    ex_mem_size;
    logic [2:0]    ex_br_cond;
    logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic          mem_misalign, mem_br_taken, fwd_valid;
    logic [31:0]   mem_alu_out, mem_store_data, mem_br_target, fwd_data;
    logic [4:0]    mem_rd, fwd_rd;
    logic [1:0]    mem_mem_size;
    logic [CW-1:0] br_taken_cnt;

    always #5 clk = ~clk;

    ex_mem_stage #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_alu_out     (ex_alu_out),
        .ex_z           (ex_z),
        .ex_n           (ex_n),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_size    (ex_mem_size),
        .ex_br_cond     (ex_br_cond),
        .ex_br_target   (ex_br_target),
        .mem_valid      (mem_valid),
        .mem_alu_out    (mem_alu_out),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_size   (mem_mem_size),
        .mem_misalign   (mem_misalign),
        .mem_br_taken   (mem_br_taken),
        .mem_br_target  (mem_br_target),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .br_taken_cnt   (br_taken_cnt)
    );

    typedef struct {
        logic        stall, flush, valid, z, n, rw, mr, mw;
        logic [31:0] alu, sd, tgt;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic [2:0]  cond;
    } stim_t;

    typedef struct {
        logic          valid, rw, mr, mw, mis, bt, fwd;
        logic [31:0]   alu, sd, tgt;
        logic [4:0]    rd;
        logic [1:0]    size;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q_exp[$];
    exp_t m;
    int   taken_total;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // Flags describe a signed value v: z means v==0, n means v<0.
    function automatic logic br_eval(input logic [2:0] c, input logic z, input logic n);
        logic zero, neg, pos;
        zero = z;
        neg  = n;
        pos  = !z && !n;
        case (c)
            3'd1:    return zero;
            3'd2:    return !zero;
            3'd3:    return zero || neg;
            3'd4:    return pos;
            3'd5:    return neg;
            3'd6:    return !neg;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] acc_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 32'd1;
            2'd1:    return 32'd2;
            default: return 32'd4;
        endcase
    endfunction

    task automatic model_step(input stim_t s);
        logic mis;
        if (s.flush || (!s.stall && !s.valid)) begin
            m.valid = 1'b0;
            m.rw    = 1'b0;
            m.mr    = 1'b0;
            m.mw    = 1'b0;
            m.mis   = 1'b0;
            m.bt    = 1'b0;
        end else if (!s.stall) begin
            mis     = (s.mr || s.mw) && ((s.alu % acc_bytes(s.size)) != 32'd0);
            m.valid = 1'b1;
            m.alu   = s.alu;
            m.sd    = s.sd;
            m.tgt   = s.tgt;
            m.rd    = s.rd;
            m.size  = s.size;
            m.rw    = s.rw && !mis;
            m.mr    = s.mr && !mis;
            m.mw    = s.mw && !mis;
            m.mis   = mis;
            m.bt    = br_eval(s.cond, s.z, s.n);
            if (m.bt) taken_total++;
        end
        m.cnt = CW'(taken_total % (1 << CW));
        m.fwd = m.valid && m.rw && !m.mr && (m.rd != 5'd0);
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        stall         = s.stall;
        flush         = s.flush;
        ex_valid      = s.valid;
        ex_alu_out    = s.alu;
        ex_store_data = s.sd;
        ex_br_target  = s.tgt;
        ex_rd         = s.rd;
        ex_reg_write  = s.rw;
        ex_mem_read   = s.mr;
        ex_mem_write  = s.mw;
        ex_mem_size   = s.size;
        ex_br_cond    = s.cond;
        ex_z          = s.z;
        ex_n          = s.n;
        model_step(s);
        q_exp.push_back(m);
    endtask

    function automatic stim_t base();
        stim_t s;
        s = '{default: 0};
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.stall = ($urandom_range(0, 4) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.valid = ($urandom_range(0, 4) != 0);
        s.alu   = $urandom;
        s.sd    = $urandom;
        s.tgt   = $urandom;
        s.rd    = 5'($urandom_range(0, 31));
        s.rw    = 1'($urandom_range(0, 1));
        s.mr    = 1'($urandom_range(0, 1));
        s.mw    = 1'($urandom_range(0, 1));
        s.size  = 2'($urandom_range(0, 3));
        s.cond  = 3'($urandom_range(0, 7));
        s.z     = 1'($urandom_range(0, 1));
        s.n     = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic hold_and_drain();
        stim_t s;
        int w;
        s = base();
        s.stall = 1'b1;
        drive(s);
        w = 0;
        while (q_exp.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        chk("drain", 32'(q_exp.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_alu"}, mem_alu_out, 32'd0);
        chk({tag, "_sd"}, mem_store_data, 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_ctrl"}, 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_misalign}), 32'd0);
        chk({tag, "_bt"}, 32'(mem_br_taken), 32'd0);
        chk({tag, "_size"}, 32'(mem_mem_size), 32'd0);
        chk({tag, "_tgt"}, mem_br_target, 32'd0);
        chk({tag, "_fwd"}, 32'({fwd_valid, fwd_rd}), 32'd0);
        chk({tag, "_cnt"}, 32'(br_taken_cnt), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        m = '{default: 0};
        taken_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: one prediction per clock edge while stimulus is active.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("valid", 32'(mem_valid), 32'(e.valid));
                chk("reg_write", 32'(mem_reg_write), 32'(e.rw));
                chk("mem_read", 32'(mem_mem_read), 32'(e.mr));
                chk("mem_write", 32'(mem_mem_write), 32'(e.mw));
                chk("misalign", 32'(mem_misalign), 32'(e.mis));
                chk("br_taken", 32'(mem_br_taken), 32'(e.bt));
                chk("fwd_valid", 32'(fwd_valid), 32'(e.fwd));
                chk("cnt", 32'(br_taken_cnt), 32'(e.cnt));
                if (e.valid) begin
                    chk("alu_out", mem_alu_out, e.alu);
                    chk("store_data", mem_store_data, e.sd);
                    chk("rd", 32'(mem_rd), 32'(e.rd));
                    chk("size", 32'(mem_mem_size), 32'(e.size));
                    chk("target", mem_br_target, e.tgt);
                    chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
                    chk("fwd_data", fwd_data, e.alu);
                end
            end
        end
    end

    initial begin
        stim_t s;
        m = '{default: 0};
        taken_total = 0;
        {stall, flush, ex_valid, ex_z, ex_n, ex_reg_write, ex_mem_read, ex_mem_write} = '0;
        {ex_alu_out, ex_store_data, ex_br_target} = '0;
        ex_rd = '0;
        ex_mem_size = '0;
        ex_br_cond = '0;
        do_reset();

        // Forwarding with rd=5 and rd=0
        s = base(); s.alu = 32'h0000_1004; s.rd = 5'd5; s.rw = 1'b1; drive(s);
        s.rd = 5'd0; drive(s);
        // Branch conditions
        s = base(); s.cond = 3'b001; s.z = 1'b1; drive(s);
        s = base(); s.cond = 3'b101; s.n = 1'b0; drive(s);
        s = base(); s.cond = 3'b011; s.n = 1'b1; s.tgt = 32'h0000_2000; drive(s);
        // Stall x3 with a taken branch waiting in EX, then flush+stall
        for (int i = 0; i < 3; i++) begin
            s = base(); s.stall = 1'b1; s.cond = 3'b111; s.alu = 32'hdead_0000; drive(s);
        end
        s = base(); s.stall = 1'b1; s.flush = 1'b1; s.cond = 3'b111; drive(s);
        // Misaligned word load, then byte load at the same address
        s = base(); s.mr = 1'b1; s.rw = 1'b1; s.size = 2'b10; s.alu = 32'h0000_1002; s.rd = 5'd7;
        drive(s);
        s.size = 2'b00; drive(s);
        s.size = 2'b01; s.mr = 1'b0; s.mw = 1'b1; s.alu = 32'h0000_1001; drive(s);

        for (int i = 0; i < 400; i++) drive(rnd());

        // Asynchronous reset mid-stream while MEM holds a valid instruction
        s = base(); s.rw = 1'b1; s.rd = 5'd3; s.cond = 3'b111; s.alu = 32'h1234_5678; drive(s);
        hold_and_drain();
        chk("pre_reset_valid", 32'(mem_valid), 32'(m.valid));
        #2;
        do_reset();

        // Counter wrap: 2^CW taken branches from zero
        for (int i = 0; i < (1 << CW); i++) begin
            s = base(); s.cond = 3'b111; drive(s);
        end
        hold_and_drain();
        chk("wrap_cnt", 32'(br_taken_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
